marker_corner_tracker: RTL and testbench

- Sits directly downstream of the four-target marker detector.
- Once per video frame it takes the detector's four (x, y, diameter, valid) results and sorts them into top-left/top-right/bottom-left/bottom-right corners by comparing each against their centroid.
- It rejects degenerate frames, smooths accepted positions with a first-order IIR filter and maintains a lock status.
- Its outputs feed the perspective/overlay logic.

---
 rtl/marker_corner_tracker.sv | 222 ++++++++++++++++++++++
 tb/tb_marker_corner_tracker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/marker_corner_tracker.sv
// Corner tracker: sorts four marker detections into TL/TR/BL/BR once per frame,
// rejects degenerate frames, IIR-smooths accepted corners and keeps a lock flag.

module marker_corner_iir #(
  parameter int W     = 12,
  parameter int SHIFT = 2
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  output logic [W-1:0] nxt
);
  logic signed [W:0] diff;

  // Arithmetic shift floors toward -inf, so the step never overshoots tgt.
  assign diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
  assign nxt  = W'($signed({1'b0, cur}) + (diff >>> SHIFT));
endmodule

module marker_corner_tracker #(
  parameter int SCREEN_WIDTH  = 1280,
  parameter int SCREEN_HEIGHT = 720,
  parameter int ALPHA_SHIFT   = 2,
  parameter int LOCK_FRAMES   = 4,
  parameter int MISS_FRAMES   = 8,
  localparam int XW = $clog2(SCREEN_WIDTH) + 1,
  localparam int YW = $clog2(SCREEN_HEIGHT) + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [YW-1:0] vcount_in,
  input  logic [XW-1:0] xcount0_in,
  input  logic [XW-1:0] xcount1_in,
  input  logic [XW-1:0] xcount2_in,
  input  logic [XW-1:0] xcount3_in,
  input  logic [YW-1:0] ycount0_in,
  input  logic [YW-1:0] ycount1_in,
  input  logic [YW-1:0] ycount2_in,
  input  logic [YW-1:0] ycount3_in,
  input  logic [YW-1:0] diameter0_in,
  input  logic [YW-1:0] diameter1_in,
  input  logic [YW-1:0] diameter2_in,
  input  logic [YW-1:0] diameter3_in,
  input  logic [3:0]    valid_in,
  output logic [XW-1:0] tl_x_out,
  output logic [XW-1:0] tr_x_out,
  output logic [XW-1:0] bl_x_out,
  output logic [XW-1:0] br_x_out,
  output logic [YW-1:0] tl_y_out,
  output logic [YW-1:0] tr_y_out,
  output logic [YW-1:0] bl_y_out,
  output logic [YW-1:0] br_y_out,
  output logic [YW-1:0] diam_out,
  output logic          update_out,
  output logic          locked_out,
  output logic          busy_out
);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int MW = $clog2(MISS_FRAMES + 1);

  typedef enum logic [2:0] {IDLE, CENT, CLS0, CLS1, CLS2, CLS3, CHECK, UPD} state_t;

  state_t state, state_nxt;

  logic [YW-1:0]          prev_vcount;
  logic                   frame_end;
  logic [3:0][XW-1:0]     tgt_x;
  logic [3:0][YW-1:0]     tgt_y, tgt_d;
  logic [XW-1:0]          cx;
  logic [YW-1:0]          cy;
  logic [YW+1:0]          dsum;
  logic [XW+1:0]          sum_x;
  logic [YW+1:0]          sum_y, sum_d;
  // Slot / track index: 0=TL 1=TR 2=BL 3=BR
  logic [3:0][XW-1:0]     slot_x, trk_x, iir_x;
  logic [3:0][YW-1:0]     slot_y, trk_y, iir_y;
  logic [YW-1:0]          diam;
  logic [3:0]             filled;
  logic                   dup, frame_ok;
  logic [1:0]             cidx, slot;
  logic                   cls_en, latch, good_ev, bad_ev;
  logic [GW-1:0]          good_cnt;
  logic [MW-1:0]          miss_cnt;
  logic                   track_valid, locked, update;

  assign frame_end = (vcount_in == '0) && (prev_vcount != '0);
  assign frame_ok  = !dup && (&filled);

  always_comb begin
    sum_x = (XW+2)'(tgt_x[0]) + (XW+2)'(tgt_x[1]) + (XW+2)'(tgt_x[2]) + (XW+2)'(tgt_x[3]);
    sum_y = (YW+2)'(tgt_y[0]) + (YW+2)'(tgt_y[1]) + (YW+2)'(tgt_y[2]) + (YW+2)'(tgt_y[3]);
    sum_d = (YW+2)'(tgt_d[0]) + (YW+2)'(tgt_d[1]) + (YW+2)'(tgt_d[2]) + (YW+2)'(tgt_d[3]);
  end

  // Ties against the centroid fall to the right/bottom side.
  assign slot = {~(tgt_y[cidx] < cy), ~(tgt_x[cidx] < cx)};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    good_ev   = 1'b0;
    bad_ev    = 1'b0;
    cls_en    = 1'b0;
    cidx      = 2'd0;
    case (state)
      IDLE: if (frame_end) begin
        latch = 1'b1;
        if (&valid_in) state_nxt = CENT;
        else           bad_ev    = 1'b1;
      end
      CENT: state_nxt = CLS0;
      CLS0: begin cls_en = 1'b1; cidx = 2'd0; state_nxt = CLS1; end
      CLS1: begin cls_en = 1'b1; cidx = 2'd1; state_nxt = CLS2; end
      CLS2: begin cls_en = 1'b1; cidx = 2'd2; state_nxt = CLS3; end
      CLS3: begin cls_en = 1'b1; cidx = 2'd3; state_nxt = CHECK; end
      CHECK: begin
        if (frame_ok) state_nxt = UPD;
        else begin
          bad_ev    = 1'b1;
          state_nxt = IDLE;
        end
      end
      UPD: begin good_ev = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    marker_corner_iir #(.W(XW), .SHIFT(ALPHA_SHIFT)) u_iir_x (
      .cur(trk_x[i]), .tgt(slot_x[i]), .nxt(iir_x[i]));
    marker_corner_iir #(.W(YW), .SHIFT(ALPHA_SHIFT)) u_iir_y (
      .cur(trk_y[i]), .tgt(slot_y[i]), .nxt(iir_y[i]));
  end

  // Capture, centroid and classification datapath.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      prev_vcount <= '0;
      tgt_x       <= '0;
      tgt_y       <= '0;
      tgt_d       <= '0;
      cx          <= '0;
      cy          <= '0;
      dsum        <= '0;
      slot_x      <= '0;
      slot_y      <= '0;
      filled      <= '0;
      dup         <= 1'b0;
    end else begin
      prev_vcount <= vcount_in;
      if (latch) begin
        tgt_x <= {xcount3_in, xcount2_in, xcount1_in, xcount0_in};
        tgt_y <= {ycount3_in, ycount2_in, ycount1_in, ycount0_in};
        tgt_d <= {diameter3_in, diameter2_in, diameter1_in, diameter0_in};
      end
      if (state == CENT) begin
        cx     <= XW'(sum_x >> 2);
        cy     <= YW'(sum_y >> 2);
        dsum   <= sum_d;
        filled <= '0;
        dup    <= 1'b0;
      end
      if (cls_en) begin
        slot_x[slot] <= tgt_x[cidx];
        slot_y[slot] <= tgt_y[cidx];
        filled[slot] <= 1'b1;
        if (filled[slot]) dup <= 1'b1;
      end
    end
  end

  // Track outputs and lock bookkeeping.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      trk_x       <= '0;
      trk_y       <= '0;
      diam        <= '0;
      update      <= 1'b0;
      track_valid <= 1'b0;
      locked      <= 1'b0;
      good_cnt    <= '0;
      miss_cnt    <= '0;
    end else begin
      update <= good_ev;
      if (good_ev) begin
        trk_x       <= track_valid ? iir_x : slot_x;
        trk_y       <= track_valid ? iir_y : slot_y;
        diam        <= YW'(dsum >> 2);
        track_valid <= 1'b1;
        miss_cnt    <= '0;
        if (good_cnt != GW'(LOCK_FRAMES)) good_cnt <= good_cnt + 1'b1;
        if (good_cnt >= GW'(LOCK_FRAMES - 1)) locked <= 1'b1;
      end
      if (bad_ev) begin
        good_cnt <= '0;
        if (miss_cnt != MW'(MISS_FRAMES)) miss_cnt <= miss_cnt + 1'b1;
        // A lost track forces the next good frame to reload instead of smoothing.
        if (miss_cnt >= MW'(MISS_FRAMES - 1)) begin
          locked      <= 1'b0;
          track_valid <= 1'b0;
        end
      end
    end
  end

  assign tl_x_out   = trk_x[0];
  assign tr_x_out   = trk_x[1];
  assign bl_x_out   = trk_x[2];
  assign br_x_out   = trk_x[3];
  assign tl_y_out   = trk_y[0];
  assign tr_y_out   = trk_y[1];
  assign bl_y_out   = trk_y[2];
  assign br_y_out   = trk_y[3];
  assign diam_out   = diam;
  assign update_out = update;
  assign locked_out = locked;
  assign busy_out   = (state != IDLE);
endmodule

// File: tb/tb_marker_corner_tracker.sv
// Bench for marker_corner_tracker: directed corner/lock scenarios plus random frames,
// all checked every cycle against a frame-level behavioural model.

module tb_marker_corner_tracker;
  localparam int XW = 12;
  localparam int YW = 11;
  localparam int ALPHA = 2;
  localparam int LOCKN = 4;
  localparam int MISSN = 8;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [YW-1:0] vcount_in;
  logic [XW-1:0] tx [4];
  logic [YW-1:0] ty [4];
  logic [YW-1:0] td [4];
  logic [3:0]    valid_in;
  logic [XW-1:0] tl_x_out, tr_x_out, bl_x_out, br_x_out;
  logic [YW-1:0] tl_y_out, tr_y_out, bl_y_out, br_y_out, diam_out;
  logic          update_out, locked_out, busy_out;

  int checks = 0;
  int errors = 0;

  marker_corner_tracker dut (
    .clk_in(clk_in), .rst_in(rst_in), .vcount_in(vcount_in),
    .xcount0_in(tx[0]), .xcount1_in(tx[1]), .xcount2_in(tx[2]), .xcount3_in(tx[3]),
    .ycount0_in(ty[0]), .ycount1_in(ty[1]), .ycount2_in(ty[2]), .ycount3_in(ty[3]),
    .diameter0_in(td[0]), .diameter1_in(td[1]), .diameter2_in(td[2]), .diameter3_in(td[3]),
    .valid_in(valid_in),
    .tl_x_out(tl_x_out), .tr_x_out(tr_x_out), .bl_x_out(bl_x_out), .br_x_out(br_x_out),
    .tl_y_out(tl_y_out), .tr_y_out(tr_y_out), .bl_y_out(bl_y_out), .br_y_out(br_y_out),
    .diam_out(diam_out), .update_out(update_out), .locked_out(locked_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (frame level) ----------------
  int ox [4], oy [4];      // expected corners, 0=TL 1=TR 2=BL 3=BR
  int nx [4], ny [4];      // corners computed for the frame in flight
  int m_diam, f_dsum, m_good, m_miss, k;
  bit m_upd, m_lock, m_tv, f_good;
  int m_prev;
  int px [4], py [4], pd [4];
  int p_v, p_val;
  bit p_rst = 1'b0;

  function automatic void evaluate();
    int sx, sy, cxm, cym, q;
    int cnt [4];
    sx = 0; sy = 0; f_dsum = 0;
    for (int i = 0; i < 4; i++) begin
      sx += px[i]; sy += py[i]; f_dsum += pd[i]; cnt[i] = 0;
    end
    cxm = sx / 4;
    cym = sy / 4;
    for (int i = 0; i < 4; i++) begin
      q = ((py[i] >= cym) ? 2 : 0) + ((px[i] >= cxm) ? 1 : 0);
      cnt[q]++;
      nx[q] = px[i];
      ny[q] = py[i];
    end
    f_good = (cnt[0] == 1) && (cnt[1] == 1) && (cnt[2] == 1) && (cnt[3] == 1);
  endfunction

  function automatic void good_frame();
    for (int q = 0; q < 4; q++) begin
      if (!m_tv) begin
        ox[q] = nx[q]; oy[q] = ny[q];
      end else begin
        ox[q] = ox[q] + ((nx[q] - ox[q]) >>> ALPHA);
        oy[q] = oy[q] + ((ny[q] - oy[q]) >>> ALPHA);
      end
    end
    m_diam = f_dsum / 4;
    m_tv = 1'b1;
    m_upd = 1'b1;
    m_miss = 0;
    if (m_good < LOCKN) m_good++;
    if (m_good == LOCKN) m_lock = 1'b1;
  endfunction

  function automatic void bad_frame();
    m_good = 0;
    if (m_miss < MISSN) m_miss++;
    if (m_miss == MISSN) begin
      m_lock = 1'b0;
      m_tv = 1'b0;
    end
  endfunction

  // k counts clock edges since the frame-end edge while a frame is in flight.
  function automatic void model_step();
    if (!rst_in || !p_rst) begin
      for (int q = 0; q < 4; q++) begin ox[q] = 0; oy[q] = 0; end
      m_diam = 0; m_upd = 0; m_lock = 0; m_tv = 0;
      m_good = 0; m_miss = 0; m_prev = 0; k = -1;
    end else begin
      m_upd = 1'b0;
      if (k >= 0) begin
        k++;
        if (k == 6 && !f_good) begin bad_frame(); k = -1; end
        else if (k == 7) begin good_frame(); k = -1; end
      end else if (p_v == 0 && m_prev != 0) begin
        if (p_val == 15) begin evaluate(); k = 0; end
        else bad_frame();
      end
      m_prev = p_v;
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk_in);
      model_step();
      chk("tl_x", int'(tl_x_out), ox[0]);
      chk("tl_y", int'(tl_y_out), oy[0]);
      chk("tr_x", int'(tr_x_out), ox[1]);
      chk("tr_y", int'(tr_y_out), oy[1]);
      chk("bl_x", int'(bl_x_out), ox[2]);
      chk("bl_y", int'(bl_y_out), oy[2]);
      chk("br_x", int'(br_x_out), ox[3]);
      chk("br_y", int'(br_y_out), oy[3]);
      chk("diam", int'(diam_out), m_diam);
      chk("update", int'(update_out), int'(m_upd));
      chk("locked", int'(locked_out), int'(m_lock));
      chk("busy", int'(busy_out), (k >= 0) ? 1 : 0);
      for (int i = 0; i < 4; i++) begin
        px[i] = int'(tx[i]); py[i] = int'(ty[i]); pd[i] = int'(td[i]);
      end
      p_v = int'(vcount_in);
      p_val = int'(valid_in);
      p_rst = rst_in;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic set_t(input int i, input int x, input int y, input int d);
    tx[i] = XW'(x); ty[i] = YW'(y); td[i] = YW'(d);
  endtask

  task automatic load_a();
    set_t(0, 900, 600, 10); set_t(1, 100, 100, 12);
    set_t(2, 900, 100, 14); set_t(3, 100, 600, 16);
  endtask

  // gap=8 leaves the bench in the cycle right after the UPD edge.
  task automatic frame(input logic [3:0] v, input int gap);
    valid_in  = v;
    vcount_in = YW'($urandom_range(1, 719));
    tick();
    vcount_in = '0;
    repeat (gap) tick();
  endtask

  task automatic chk_corners(input string nm, input int tlx, input int tly,
                             input int brx, input int bry);
    chk({nm, "_tl_x"}, int'(tl_x_out), tlx);
    chk({nm, "_tl_y"}, int'(tl_y_out), tly);
    chk({nm, "_br_x"}, int'(br_x_out), brx);
    chk({nm, "_br_y"}, int'(br_y_out), bry);
  endtask

  initial begin
    rst_in = 1'b0;
    vcount_in = '0;
    valid_in = '0;
    for (int i = 0; i < 4; i++) set_t(i, 0, 0, 0);
    repeat (3) tick();
    chk("rst_tl_x", int'(tl_x_out), 0);
    chk("rst_locked", int'(locked_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    rst_in = 1'b1;
    tick();

    // first frame loads directly
    load_a();
    frame(4'hF, 8);
    chk_corners("first", 100, 100, 900, 600);
    chk("first_tr_x", int'(tr_x_out), 900);
    chk("first_bl_y", int'(bl_y_out), 600);
    chk("first_diam", int'(diam_out), 13);
    chk("first_upd", int'(update_out), 1);
    tick();
    chk("first_upd_1cyc", int'(update_out), 0);

    // TL moved to 140 -> smoothed to 110
    set_t(1, 140, 100, 12);
    frame(4'hF, 8);
    chk_corners("smooth", 110, 100, 900, 600);
    chk("smooth_upd", int'(update_out), 1);
    chk("smooth_lock3", int'(locked_out), 0);

    load_a();
    frame(4'hF, 8);
    chk("third_tl_x", int'(tl_x_out), 107);
    chk("third_lock", int'(locked_out), 0);
    frame(4'hF, 8);
    chk("fourth_tl_x", int'(tl_x_out), 105);
    chk("fourth_lock", int'(locked_out), 1);

    // one bad frame then a good one keeps lock
    frame(4'hE, 8);
    chk("bad_upd", int'(update_out), 0);
    chk("bad_lock", int'(locked_out), 1);
    chk("bad_hold", int'(tl_x_out), 105);
    frame(4'hF, 8);
    chk("regood_tl_x", int'(tl_x_out), 103);
    chk("regood_lock", int'(locked_out), 1);

    // collinear targets: duplicate quadrant, rejected (miss 1)
    set_t(0, 100, 100, 10); set_t(1, 200, 100, 10);
    set_t(2, 300, 100, 10); set_t(3, 400, 100, 10);
    frame(4'hF, 8);
    chk("colin_upd", int'(update_out), 0);
    chk("colin_hold", int'(tl_x_out), 103);
    repeat (6) frame(4'hE, 8);
    chk("miss7_lock", int'(locked_out), 1);
    frame(4'hE, 8);
    chk("miss8_lock", int'(locked_out), 0);

    // after track loss the next good frame reloads directly
    set_t(0, 700, 500, 20); set_t(1, 200, 150, 20);
    set_t(2, 650, 120, 20); set_t(3, 180, 520, 21);
    frame(4'hF, 8);
    chk_corners("reload", 200, 150, 700, 500);
    chk("reload_tr_y", int'(tr_y_out), 120);
    chk("reload_diam", int'(diam_out), 20);

    // reset asserted at E+4
    load_a();
    valid_in = 4'hF;
    vcount_in = 11'd33;
    tick();
    vcount_in = '0;
    repeat (4) tick();
    chk("pre_rst_busy", int'(busy_out), 1);
    rst_in = 1'b0;
    #1;
    chk("midrst_tl_x", int'(tl_x_out), 0);
    chk("midrst_br_y", int'(br_y_out), 0);
    chk("midrst_busy", int'(busy_out), 0);
    repeat (2) tick();
    rst_in = 1'b1;
    tick();
    frame(4'hF, 8);
    chk_corners("postrst", 100, 100, 900, 600);
    chk("postrst_upd", int'(update_out), 1);

    // randomized frames, including ties, invalid flags and short frame periods
    repeat (250) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0)
          set_t(i, 100 * $urandom_range(1, 3), 100 * $urandom_range(1, 3),
                $urandom_range(0, 2047));
        else
          set_t(i, $urandom_range(0, 1279), $urandom_range(0, 719),
                $urandom_range(0, 2047));
      end
      if ($urandom_range(0, 5) == 0) frame(4'($urandom_range(0, 15)), $urandom_range(2, 14));
      else                           frame(4'hF, $urandom_range(2, 14));
    end
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
